// File: rtl/pc_branch_sequencer.sv
// Multi-cycle PC sequencer: owns the PC and shares a single 32-bit adder between PC+4 and branch-target math.
// Latency: accept edge to pc_valid with new pc is 1 cycle (sequential / not taken), 2 cycles (taken branch / jump).
// Backpressure: instr_ready is low while in INC/BR; descriptors offered then are ignored. Optional macro: BRANCH_COUNT_EN.
module pc_branch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMM_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        is_branch,
  input  logic        alu_zero,
  input  logic        is_jump,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        pc_valid
`ifdef BRANCH_COUNT_EN
  ,
  output logic [15:0] taken_count
`endif
);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_INC  = 2'd1,
    S_BR   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_4;
  logic        r_taken;
  logic        r_jump;
  logic [15:0] r_imm;
  logic [25:0] r_jaddr;
  logic        r_valid;

  logic [31:0] w_imm_sext;
  logic [31:0] w_offset;
  logic [31:0] w_add_a;
  logic [31:0] w_add_b;
  logic [31:0] w_sum;

  // Shared adder: BR computes pc_4 + scaled offset, every other state computes pc + 4.
  always_comb begin
    w_imm_sext = {{16{r_imm[15]}}, r_imm};
    w_offset   = w_imm_sext << IMM_SHIFT;
    w_add_a    = (r_state == S_BR) ? r_pc_4   : r_pc;
    w_add_b    = (r_state == S_BR) ? w_offset : 32'd4;
    w_sum      = w_add_a + w_add_b;
  end

  // Sequencer FSM; pc only changes on the transitions back into WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_WAIT;
      r_pc    <= RESET_PC;
      r_pc_4  <= '0;
      r_taken <= 1'b0;
      r_jump  <= 1'b0;
      r_imm   <= '0;
      r_jaddr <= '0;
      r_valid <= 1'b1;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (instr_valid) begin
            r_taken <= is_branch & alu_zero;
            r_jump  <= is_jump;
            r_imm   <= imm;
            r_jaddr <= jaddr;
            r_state <= S_INC;
            r_valid <= 1'b0;
          end
        end
        S_INC: begin
          r_pc_4 <= w_sum;
          if (r_jump || r_taken) begin
            r_state <= S_BR;
          end else begin
            r_pc    <= w_sum;
            r_state <= S_WAIT;
            r_valid <= 1'b1;
          end
        end
        S_BR: begin
          // Jump wins over a taken branch; it bypasses the adder entirely.
          if (r_jump) begin
            r_pc <= {r_pc_4[31:28], r_jaddr, 2'b00};
          end else begin
            r_pc <= w_sum;
          end
          r_state <= S_WAIT;
          r_valid <= 1'b1;
        end
        default: begin
          r_state <= S_WAIT;
          r_valid <= 1'b1;
        end
      endcase
    end
  end

`ifdef BRANCH_COUNT_EN
  logic [15:0] r_taken_count;

  // Saturating count of redirects (every BR -> WAIT transition).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken_count <= '0;
    end else if (r_state == S_BR && r_taken_count != 16'hFFFF) begin
      r_taken_count <= r_taken_count + 16'd1;
    end
  end

  assign taken_count = r_taken_count;
`endif

  assign pc          = r_pc;
  assign pc_4        = r_pc_4;
  assign pc_valid    = r_valid;
  assign instr_ready = r_valid;

endmodule
